// File: rtl/io_bitbang_ctrl.sv
// io_bitbang_ctrl: byte-command GPIO controller (direction/outval load, toggle, pin readback).
// Define IO_BITBANG_CTRL_SYNC_EN to pass in_io_inputval through a 2-flop synchronizer.
module io_bitbang_ctrl #(
  parameter int IO_NUM_OF = 10
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [7:0]           in_cmd_data,
  input  logic                 in_cmd_valid,
  output logic                 out_cmd_ready,
  output logic [7:0]           out_rsp_data,
  output logic                 out_rsp_valid,
  input  logic                 in_rsp_ready,
  output logic [IO_NUM_OF-1:0] out_io_direction,
  output logic [IO_NUM_OF-1:0] out_io_outval,
  input  logic [IO_NUM_OF-1:0] in_io_inputval,
  output logic                 out_err
);
  localparam int NB = (IO_NUM_OF + 7) / 8;
  localparam int W = NB * 8;
  typedef enum logic [1:0] {IDLE, ARG, RSP} state_t;
  state_t state, state_next;
  logic [2:0] op;
  logic [1:0] cnt;
  logic [W-1:0] shreg, snap, arg_full;
  logic [IO_NUM_OF-1:0] pins, arg_val;
  logic acc, rsp_hs, last;
`ifdef IO_BITBANG_CTRL_SYNC_EN
  logic [IO_NUM_OF-1:0] sync1, sync2;
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) {sync2, sync1} <= '0;
    else {sync2, sync1} <= {sync1, in_io_inputval};
  assign pins = sync2;
`else
  assign pins = in_io_inputval;
`endif
  assign out_cmd_ready = state != RSP;
  assign out_rsp_valid = state == RSP;
  assign out_rsp_data = snap[7:0];
  assign acc = in_cmd_valid && out_cmd_ready;
  assign rsp_hs = out_rsp_valid && in_rsp_ready;
  assign last = cnt == 2'(NB - 1);
  // Argument bytes land at their little-endian slot; the full word is only applied on the last byte.
  assign arg_full = shreg | (W'(in_cmd_data) << {cnt, 3'b000});
  assign arg_val = arg_full[IO_NUM_OF-1:0];
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (acc) state_next = (in_cmd_data == 8'h03) ? RSP :
                                  (in_cmd_data inside {8'h01, 8'h02, 8'h04}) ? ARG : IDLE;
      ARG: if (acc && last) state_next = IDLE;
      RSP: if (rsp_hs && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= IDLE;
      op <= '0;
      cnt <= '0;
      shreg <= '0;
      snap <= '0;
      out_io_direction <= '0;
      out_io_outval <= '0;
      out_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && acc) begin
        op <= in_cmd_data[2:0];
        cnt <= '0;
        shreg <= '0;
        if (in_cmd_data == 8'h00) out_err <= 1'b0;
        else if (in_cmd_data > 8'h04) out_err <= 1'b1;
        if (in_cmd_data == 8'h03) snap <= W'(pins);
      end
      if (state == ARG && acc) begin
        cnt <= cnt + 2'd1;
        shreg <= arg_full;
        if (last) begin
          if (op == 3'd1) out_io_direction <= arg_val;
          out_io_outval <= (op == 3'd2) ? arg_val : (op == 3'd4) ? out_io_outval ^ arg_val : out_io_outval;
        end
      end
      if (state == RSP && rsp_hs) begin
        snap <= snap >> 8;
        cnt <= cnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_io_bitbang_ctrl.sv
// tb_io_bitbang_ctrl: directed scoreboard bench for io_bitbang_ctrl (IO_NUM_OF = 10).
module tb_io_bitbang_ctrl;
  logic       in_clk = 0, in_rst = 1;
  logic [7:0] in_cmd_data = 0;
  logic       in_cmd_valid = 0, in_rsp_ready = 0;
  logic       out_cmd_ready, out_rsp_valid, out_err;
  logic [7:0] out_rsp_data;
  logic [9:0] out_io_direction, out_io_outval, in_io_inputval = 0;
  int errors = 0, checks = 0;
  logic [7:0] q[$];

  io_bitbang_ctrl #(.IO_NUM_OF(10)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_cmd_data(in_cmd_data), .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready),
    .out_rsp_data(out_rsp_data), .out_rsp_valid(out_rsp_valid), .in_rsp_ready(in_rsp_ready),
    .out_io_direction(out_io_direction), .out_io_outval(out_io_outval),
    .in_io_inputval(in_io_inputval), .out_err(out_err)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_cmd_data = b;
    in_cmd_valid = 1;
    @(posedge in_clk);
    #1 in_cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    in_rsp_ready = 1;
    while (q.size() > 0 && n < 20) begin
      if (out_rsp_valid) begin
        check("rsp_data", out_rsp_data, q.pop_front());
        check("rsp_cmd_ready", out_cmd_ready, 0);
      end
      @(negedge in_clk);
      n++;
    end
    check("rsp_drain_timeout", q.size(), 0);
    check("rsp_valid_drop", out_rsp_valid, 0);
    check("rsp_done_ready", out_cmd_ready, 1);
    in_rsp_ready = 0;
    q.delete();
  endtask

  initial begin
    repeat (2) @(negedge in_clk);
    check("rst_dir", out_io_direction, 0);
    check("rst_out", out_io_outval, 0);
    check("rst_rsp_valid", out_rsp_valid, 0);
    check("rst_rsp_data", out_rsp_data, 0);
    check("rst_err", out_err, 0);
    check("rst_cmd_ready", out_cmd_ready, 1);
    in_io_inputval = 10'h2A5;
    @(posedge in_clk);
    #1 in_rst = 0;
    // SET_DIR: no partial update after first argument byte
    send(8'h01);
    send(8'hFF);
    check("dir_partial", out_io_direction, 0);
    send(8'h03);
    check("dir_load", out_io_direction, 10'h3FF);
    // SET_OUT then TOGGLE_OUT
    send(8'h02); send(8'hF0); send(8'h00);
    check("out_load", out_io_outval, 10'h0F0);
    send(8'h04); send(8'hFF);
    check("tog_partial", out_io_outval, 10'h0F0);
    send(8'h01);
    check("tog", out_io_outval, 10'h10F);
    // READ with backpressure
    send(8'h03);
    q.push_back(8'hA5);
    q.push_back(8'h02);
    repeat (5) begin
      @(negedge in_clk);
      check("hold_valid", out_rsp_valid, 1);
      check("hold_data", out_rsp_data, q[0]);
      check("hold_cmd_ready", out_cmd_ready, 0);
    end
    drain();
    // Illegal opcode, error does not block commands, CLR_ERR
    send(8'h7E);
    check("err_set", out_err, 1);
    check("err_idle", out_cmd_ready, 1);
    send(8'h01); send(8'h0F); send(8'h00);
    check("err_nonblock", out_io_direction, 10'h00F);
    check("err_sticky", out_err, 1);
    send(8'h00);
    check("err_clr", out_err, 0);
    // Reset mid-argument
    send(8'h02); send(8'h55);
    in_rst = 1;
    #1;
    check("midrst_out", out_io_outval, 0);
    check("midrst_dir", out_io_direction, 0);
    @(posedge in_clk);
    #1 in_rst = 0;
    send(8'h02); send(8'h33);
    check("post_rst_partial", out_io_outval, 0);
    send(8'h00);
    check("post_rst_load", out_io_outval, 10'h033);
    // Input edge one cycle before READ accept
    in_io_inputval = 10'h15A;
    send(8'h03);
`ifdef IO_BITBANG_CTRL_SYNC_EN
    q.push_back(8'hA5);
    q.push_back(8'h02);
`else
    q.push_back(8'h5A);
    q.push_back(8'h01);
`endif
    @(negedge in_clk);
    drain();
    // TOGGLE full mask, no-op toggle of zero
    send(8'h04); send(8'hFF); send(8'h03);
    check("tog_full", out_io_outval, 10'h033 ^ 10'h3FF);
    send(8'h04); send(8'h00); send(8'h00);
    check("tog_zero", out_io_outval, 10'h033 ^ 10'h3FF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
